// File: rtl/dmem_bridge.sv
// dmem_bridge: MEM-stage data memory bridge with big-endian lane steering and pipeline stall.
// Spec bit 0 (MSB) is numeric bit 31 here. Optional DMEM_TIMEOUT_EN aborts accesses that wait TIMEOUT_CYCLES.
module dmem_bridge #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] proc_addr,
  input  logic [31:0] proc_wdata,
  input  logic        proc_we,
  input  logic        proc_re,
  input  logic        proc_byte,
  input  logic        proc_half,
  input  logic        proc_sext,
  output logic [31:0] proc_rdata,
  output logic        proc_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;
  logic go, tmo;
  logic lat_byte, lat_half, lat_sext;
  logic [1:0] lane, lat_lane;
  logic [7:0] rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_fmt;
  if (TIMEOUT_CYCLES < 1) $error("TIMEOUT_CYCLES must be at least 1");
  assign go = proc_we | proc_re;
  assign lane = proc_addr[1:0];
`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (state == REQ) ? cnt + 1'b1 : '0;
  // a ready arriving on the limit cycle completes normally
  assign tmo = (state == REQ) && !mem_ready && (cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clock or negedge reset)
    if (!reset) err <= 1'b0;
    else if (tmo) err <= 1'b1;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == IDLE) ? (go ? REQ : IDLE)
             : (state == REQ) ? ((mem_ready | tmo) ? DONE : REQ)
             : IDLE;
    mem_req = (state == REQ);
    proc_stall = reset & ((state == REQ) | ((state == IDLE) & go));
  end
  // lane 0 is the most significant byte
  always_comb begin
    rd_byte = mem_rdata[{~lat_lane, 3'b000} +: 8];
    rd_half = lat_lane[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    rd_fmt = lat_byte ? {{24{lat_sext & rd_byte[7]}}, rd_byte}
           : lat_half ? {{16{lat_sext & rd_half[15]}}, rd_half}
           : mem_rdata;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      proc_rdata <= '0;
      lat_byte <= 1'b0;
      lat_half <= 1'b0;
      lat_sext <= 1'b0;
      lat_lane <= '0;
    end else begin
      if (state == IDLE && go) begin
        mem_we <= proc_we;
        mem_addr <= {proc_addr[31:2], 2'b00};
        mem_wdata <= proc_byte ? {4{proc_wdata[7:0]}} : proc_half ? {2{proc_wdata[15:0]}} : proc_wdata;
        mem_wstrb <= proc_byte ? (4'b1000 >> lane) : proc_half ? (lane[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        lat_byte <= proc_byte;
        lat_half <= proc_half & ~proc_byte;
        lat_sext <= proc_sext;
        lat_lane <= lane;
      end
      if (state == REQ && mem_ready && !mem_we) proc_rdata <= rd_fmt;
      else if (tmo) proc_rdata <= '0;
    end
endmodule
